vec_demux2_reg: RTL and testbench
=================================

Name: vec_demux2_reg

Overview:
- Registered 2-way vector demultiplexer with valid/ready handshakes.
- Accepts one DEPTH-lane vector per transfer and steers it, under in_sel, to one of two destinations (sel=0 -> out0, sel=1 -> out1).
- Each destination has a one-entry output slot.
- Inverse of the 2-input vector mux on the vector datapath: it sits between the vector register-file read/ALU result path and two consumers (e.g. vector writeback vs. vector store unit).

Parameters:
WIDTH, 32, bits per lane
DEPTH, 4, number of lanes per vector

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  producer offers a vector this cycle
in_ready  output  1  block accepts the offered vector this cycle
in_sel  input  1  destination select, 0 -> out0, 1 -> out1; sampled only when in_valid=1
in_data  input  [WIDTH-1:0] x [0:DEPTH-1]  input vector (unpacked lane array)
out0_valid  output  1  slot 0 holds a vector
out0_ready  input  1  consumer 0 takes the vector this cycle
out0_data  output  [WIDTH-1:0] x [0:DEPTH-1]  slot 0 contents
out1_valid  output  1  slot 1 holds a vector
out1_ready  input  1  consumer 1 takes the vector this cycle
out1_data  output  [WIDTH-1:0] x [0:DEPTH-1]  slot 1 contents

Behaviour:
- Reset (rst=1 at rising edge):
  - Both slots go EMPTY; out0_valid=out1_valid=0.
  - out0_data/out1_data all lanes = 0.
  - Any held vector is discarded, including mid-handshake.
  - in_ready is forced 0 while rst=1.
- Per-slot state machine, k in {0,1}:
  - EMPTY -> FULL on accept with in_sel=k.
  - FULL -> EMPTY on outk_valid & outk_ready with no new accept to k.
  - FULL -> FULL (data replaced) on simultaneous drain and accept to k.
- Slot drain condition: drain_k = outk_valid & outk_ready.
- in_ready (combinational from slot state, outk_ready, in_sel, rst):
  - in_ready = !rst & (in_sel ? (!out1_valid | out1_ready) : (!out0_valid | out0_ready)).
  - in_ready depends on in_sel and may change when in_sel changes while in_valid=1.
- Accept = in_valid & in_ready.
  - On accept, all DEPTH lanes of in_data are copied into slot[in_sel] at the clock edge.
  - outk_valid rises the next cycle, so input-to-output latency is 1 cycle.
- No combinational path from in_data/in_valid to any out* signal; outputs come straight from registers.
- Per-output throughput is 1 vector/cycle when the consumer holds outk_ready=1 (full-throughput pass-through via the simultaneous drain+accept case).
- Stability rules:
  - While outk_valid=1 and outk_ready=0, outk_data is held stable.
  - The non-selected slot is never modified by an accept.
- Independence and ordering:
  - The two slots drain independently.
  - There is no ordering guarantee between out0 and out1.
  - Ordering within one destination is preserved.
- Backpressure: a blocked destination does not block traffic to the other destination. in_ready is evaluated against the slot named by the current in_sel only.
- Width rule: lanes are copied bit-exact; there is no arithmetic, truncation or extension.
- Protocol assumption checked by assertions in the bench: the producer holds in_data/in_sel stable while in_valid=1 and in_ready=0.

Decomposition:
- Package vec_pkg:
  - localparams VEC_WIDTH=32, VEC_DEPTH=4.
  - typedef vec_t = logic [VEC_WIDTH-1:0] [0:VEC_DEPTH-1]-style unpacked lane array alias.
  - typedef enum {SLOT_EMPTY, SLOT_FULL} slot_state_t.
- Sub-module vec_slot:
  - One-entry registered valid/ready stage with load, drain, valid, data.
  - Instantiated twice.
  - The top level holds only the steering and in_ready logic.

Test Plan:
1. Reset, then in_sel=0, in_data lanes {0,1,2,3}, in_valid=1 for one cycle, out0_ready=0 -> in_ready=1 on that cycle. Next cycle out0_valid=1, out0_data={0,1,2,3}, out1_valid=0. Data holds for 5 cycles until out0_ready=1, then out0_valid=0 the following cycle.
2. in_sel=1, lanes {4,5,6,7} -> out1_valid=1, out1_data={4,5,6,7}, out0 untouched.
3. Stall/independence:
   - Fill slot 0 with out0_ready=0.
   - Offer in_sel=0 with {8,9,A,B} -> in_ready=0.
   - Switch in_sel=1 -> in_ready=1, and out1 receives {8,9,A,B} while out0 still holds the first vector.
4. Streaming with out0_ready=1 constant, 8 back-to-back vectors (lane i of vector n = 16n+i) to sel=0 -> in_ready=1 every cycle. out0 shows vector n at cycle n+1, in order, with no bubbles.
5. Simultaneous drain+accept: slot 1 FULL with {1,1,1,1}, out1_ready=1, and accept {2,2,2,2} to sel=1 the same cycle -> next cycle out1_valid=1 with {2,2,2,2}; {1,1,1,1} was consumed exactly once.
6. Reset mid-operation: both slots FULL, assert rst for one cycle -> out0_valid=out1_valid=0, data=0, and in_ready=0 during rst. The first accept after reset behaves as in scenario 1.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared types for the vector demux: lane geometry, the vector alias and the slot state encoding.
package vec_pkg;

  localparam int VEC_WIDTH = 32;
  localparam int VEC_DEPTH = 4;

  typedef logic [VEC_WIDTH-1:0] vec_t [0:VEC_DEPTH-1];

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/vec_slot.sv
// One-entry registered valid/ready holding stage for a DEPTH-lane vector.
// A load in the same cycle as a drain replaces the contents, so the stage can pass one vector per cycle.
module vec_slot
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH,
  parameter int DEPTH = VEC_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i [0:DEPTH-1],
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o [0:DEPTH-1]
);

  slot_state_t state_q, state_d;
  logic        drain;

  assign valid_o = (state_q == SLOT_FULL);
  assign drain   = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_EMPTY: if (load_i) state_d = SLOT_FULL;
      SLOT_FULL:  if (drain && !load_i) state_d = SLOT_EMPTY;
      default:    state_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SLOT_EMPTY;
    else     state_q <= state_d;
  end

  // Lanes only change on load, which keeps data stable while the consumer stalls.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_lane
    logic [WIDTH-1:0] lane_q;

    always_ff @(posedge clk) begin
      if (rst)         lane_q <= '0;
      else if (load_i) lane_q <= load_data_i[gi];
    end

    assign data_o[gi] = lane_q;
  end

endmodule

// File: rtl/vec_demux2_reg.sv
// Registered 2-way vector demultiplexer: steers each accepted vector into out0 or out1 by in_sel.
// Only steering and in_ready live here; each destination is an independent vec_slot.
module vec_demux2_reg
  import vec_pkg::*;
#(
  parameter int WIDTH = VEC_WIDTH,
  parameter int DEPTH = VEC_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data [0:DEPTH-1],
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data [0:DEPTH-1],
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data [0:DEPTH-1]
);

  logic room0, room1;
  logic accept;

  // A slot has room when empty or being drained this cycle; only the selected slot gates in_ready.
  assign room0    = !out0_valid | out0_ready;
  assign room1    = !out1_valid | out1_ready;
  assign in_ready = !rst & (in_sel ? room1 : room0);
  assign accept   = in_valid & in_ready;

  vec_slot #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept & !in_sel),
    .load_data_i(in_data),
    .ready_i    (out0_ready),
    .valid_o    (out0_valid),
    .data_o     (out0_data)
  );

  vec_slot #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept & in_sel),
    .load_data_i(in_data),
    .ready_i    (out1_ready),
    .valid_o    (out1_valid),
    .data_o     (out1_data)
  );

endmodule

// File: tb/tb_vec_demux2_reg.sv
// Bench for vec_demux2_reg: per-destination queue model checked every cycle, plus directed literal checks.
module tb_vec_demux2_reg;
  import vec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sel = 1'b0, out0_ready = 1'b0, out1_ready = 1'b0;
  logic in_ready, out0_valid, out1_valid;
  vec_t in_data, out0_data, out1_data;

  int tests = 0;
  int fails = 0;

  vec_t q0[$];
  vec_t q1[$];
  bit   live = 1'b0;
  int   hs1 = 0;
  logic [127:0] last1 = '0;

  bit          stall_q = 1'b0;
  logic        sel_q = 1'b0;
  logic [127:0] data_q = '0;

  always #5 clk = ~clk;

  vec_demux2_reg #(.WIDTH(VEC_WIDTH), .DEPTH(VEC_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data)
  );

  function automatic logic [127:0] pk(input vec_t v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  // A destination can take a vector if its queue is empty or its consumer drains this cycle.
  function automatic bit exp_ready();
    if (rst) return 1'b0;
    if (in_sel) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic sel, input vec_t v);
    in_sel   = sel;
    in_data  = v;
    in_valid = 1'b1;
  endtask

  // Model: each destination is a FIFO of vectors in acceptance order.
  always @(posedge clk) begin
    bit acc, d0, d1;
    if (stall_q)
      assert (in_sel == sel_q && pk(in_data) == data_q)
        else $error("producer changed its offer while stalled");
    if (out1_valid && out1_ready && !rst) begin
      hs1++;
      last1 = pk(out1_data);
    end
    live = 1'b1;
    if (rst) begin
      q0.delete();
      q1.delete();
      stall_q = 1'b0;
    end else begin
      acc     = in_valid && exp_ready();
      d0      = (q0.size() != 0) && out0_ready;
      d1      = (q1.size() != 0) && out1_ready;
      stall_q = in_valid && !exp_ready();
      sel_q   = in_sel;
      data_q  = pk(in_data);
      if (d0) void'(q0.pop_front());
      if (d1) void'(q1.pop_front());
      if (acc) begin
        if (in_sel) q1.push_back(in_data);
        else        q0.push_back(in_data);
        $display("[TB] accept sel=%0d data=%h", in_sel, pk(in_data));
      end
    end
  end

  always @(negedge clk) begin
    if (live) begin
      chk("model in_ready", {127'b0, in_ready}, {127'b0, exp_ready()});
      chk("model out0_valid", {127'b0, out0_valid}, {127'b0, q0.size() != 0});
      chk("model out1_valid", {127'b0, out1_valid}, {127'b0, q1.size() != 0});
      if (q0.size() != 0) chk("model out0_data", pk(out0_data), pk(q0[0]));
      if (q1.size() != 0) chk("model out1_data", pk(out1_data), pk(q1[0]));
    end
  end

  initial begin
    int h;
    in_data = mk(0, 0, 0, 0);
    step();
    step();
    @(negedge clk);
    chk("reset in_ready", {127'b0, in_ready}, 128'd0);
    chk("reset out0_valid", {127'b0, out0_valid}, 128'd0);
    chk("reset out1_valid", {127'b0, out1_valid}, 128'd0);
    chk("reset out0_data", pk(out0_data), 128'd0);
    chk("reset out1_data", pk(out1_data), 128'd0);
    step();
    rst = 1'b0;

    // 1: single vector to out0, held under backpressure, then drained
    offer(1'b0, mk(0, 1, 2, 3));
    @(negedge clk);
    chk("s1 in_ready", {127'b0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("s1 out0_valid", {127'b0, out0_valid}, 128'd1);
    chk("s1 out0_data", pk(out0_data), {32'd0, 32'd1, 32'd2, 32'd3});
    chk("s1 out1_valid", {127'b0, out1_valid}, 128'd0);
    repeat (5) begin
      step();
      @(negedge clk);
      chk("s1 hold", pk(out0_data), {32'd0, 32'd1, 32'd2, 32'd3});
    end
    out0_ready = 1'b1;
    step();
    out0_ready = 1'b0;
    @(negedge clk);
    chk("s1 drained", {127'b0, out0_valid}, 128'd0);

    // 2: vector to out1, out0 untouched
    offer(1'b1, mk(4, 5, 6, 7));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("s2 out1_valid", {127'b0, out1_valid}, 128'd1);
    chk("s2 out1_data", pk(out1_data), {32'd4, 32'd5, 32'd6, 32'd7});
    chk("s2 out0_valid", {127'b0, out0_valid}, 128'd0);
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;

    // 3: blocked out0 does not block out1
    offer(1'b0, mk(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    step();
    offer(1'b0, mk(8, 9, 10, 11));
    @(negedge clk);
    chk("s3 blocked in_ready", {127'b0, in_ready}, 128'd0);
    #1 in_sel = 1'b1;
    #1 chk("s3 switched in_ready", {127'b0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("s3 out1_data", pk(out1_data), {32'd8, 32'd9, 32'd10, 32'd11});
    chk("s3 out0_valid", {127'b0, out0_valid}, 128'd1);
    chk("s3 out0_data", pk(out0_data), {32'hA0, 32'hA1, 32'hA2, 32'hA3});
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    step();
    out1_ready = 1'b0;

    // 4: streaming 8 vectors to out0 with out0_ready held high
    for (int n = 0; n < 8; n++) begin
      offer(1'b0, mk(16 * n, 16 * n + 1, 16 * n + 2, 16 * n + 3));
      @(negedge clk);
      chk("s4 in_ready", {127'b0, in_ready}, 128'd1);
      if (n > 0) begin
        chk("s4 out0_valid", {127'b0, out0_valid}, 128'd1);
        chk("s4 out0_data", pk(out0_data),
            {32'(16 * (n - 1)), 32'(16 * (n - 1) + 1), 32'(16 * (n - 1) + 2), 32'(16 * (n - 1) + 3)});
      end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("s4 last", pk(out0_data), {32'd112, 32'd113, 32'd114, 32'd115});
    step();
    out0_ready = 1'b0;

    // 5: simultaneous drain and accept on slot 1
    offer(1'b1, mk(1, 1, 1, 1));
    step();
    h = hs1;
    out1_ready = 1'b1;
    offer(1'b1, mk(2, 2, 2, 2));
    @(negedge clk);
    chk("s5 in_ready", {127'b0, in_ready}, 128'd1);
    step();
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    @(negedge clk);
    chk("s5 out1_valid", {127'b0, out1_valid}, 128'd1);
    chk("s5 out1_data", pk(out1_data), {32'd2, 32'd2, 32'd2, 32'd2});
    chk("s5 consumed once", 128'(hs1 - h), 128'd1);
    chk("s5 consumed data", last1, {32'd1, 32'd1, 32'd1, 32'd1});

    // 6: reset with both slots full
    offer(1'b0, mk(32'h50, 32'h51, 32'h52, 32'h53));
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("s6 in_ready in rst", {127'b0, in_ready}, 128'd0);
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("s6 out0_valid", {127'b0, out0_valid}, 128'd0);
    chk("s6 out1_valid", {127'b0, out1_valid}, 128'd0);
    chk("s6 out0_data", pk(out0_data), 128'd0);
    chk("s6 out1_data", pk(out1_data), 128'd0);
    offer(1'b0, mk(0, 1, 2, 3));
    #1 chk("s6 post in_ready", {127'b0, in_ready}, 128'd1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("s6 post out0_data", pk(out0_data), {32'd0, 32'd1, 32'd2, 32'd3});
    chk("s6 post out0_valid", {127'b0, out0_valid}, 128'd1);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
